// File: rtl/spi_sched_pkg.sv
// Shared register map, status bit positions and FSM state type for the
// apb_2_spi transaction scheduler.
package spi_sched_pkg;

  localparam logic [3:0] OFF_TX_DATA   = 4'h0;
  localparam logic [3:0] OFF_TX_STATUS = 4'h0;
  localparam logic [3:0] OFF_RX_STATUS = 4'h4;
  localparam logic [3:0] OFF_RX_DATA   = 4'h8;
  localparam logic [3:0] OFF_N_READS   = 4'hC;

  localparam int unsigned FULL_BIT         = 3;
  localparam int unsigned ALMOST_FULL_BIT  = 2;
  localparam int unsigned EMPTY_BIT        = 1;
  localparam int unsigned ALMOST_EMPTY_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_WR_NREADS,
    ST_TX_POLL,
    ST_TX_WR,
    ST_RX_POLL,
    ST_RX_RD,
    ST_FINISH
  } sched_state_t;

endpackage

// File: rtl/apb_single_xfer.sv
// Single APB transfer engine: SETUP for one cycle, ACCESS until pready, then
// back to idle. Completion status is presented combinationally on that edge.
module apb_single_xfer #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              start,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              slverr,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [31:0]       pwdata,
  output logic [3:0]        pstrb,
  output logic [2:0]        pprot,
  input  logic [31:0]       prdata,
  input  logic              pready,
  input  logic              pslverr
);

  // Phase is encoded directly by psel/penable: idle, setup, access.
  assign busy   = psel;
  assign done   = psel & penable & pready;
  assign rdata  = prdata;
  assign slverr = done & pslverr;
  assign pprot  = '0;

  always_ff @(posedge pclk) begin
    if (preset) begin
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      pstrb   <= '0;
    end else if (!psel) begin
      if (start) begin
        psel   <= 1'b1;
        pwrite <= write;
        paddr  <= addr;
        pwdata <= write ? wdata : '0;
        pstrb  <= write ? '1 : '0;
      end
    end else if (!penable) begin
      penable <= 1'b1;
    end else if (pready) begin
      psel    <= 1'b0;
      penable <= 1'b0;
      pstrb   <= '0;
    end
  end

endmodule

// File: rtl/spi_xfer_scheduler.sv
// Round-robin sequencer sharing one apb_2_spi peripheral between N_REQ
// requesters; each grant runs one complete N_READS/TX/RX transaction.
module spi_xfer_scheduler
  import spi_sched_pkg::*;
#(
  parameter int unsigned       N_REQ     = 4,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       POLL_GAP  = 4
) (
  input  logic                 pclk,
  input  logic                 preset,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*8-1:0]   n_tx,
  input  logic [N_REQ*8-1:0]   n_rx,
  input  logic [N_REQ*8-1:0]   tx_data,
  output logic [N_REQ-1:0]     gnt,
  output logic                 tx_pop,
  output logic [7:0]           rx_data,
  output logic                 rx_valid,
  output logic [N_REQ-1:0]     done,
  output logic                 err,
  output logic [ADDR_W-1:0]    paddr,
  output logic                 psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [31:0]          pwdata,
  output logic [3:0]           pstrb,
  output logic [2:0]           pprot,
  input  logic [31:0]          prdata,
  input  logic                 pready,
  input  logic                 pslverr
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  // Scans from farthest to nearest so the nearest set bit after 'last' wins.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                             input logic [IDX_W-1:0] last);
    logic [IDX_W:0] res;
    int unsigned    idx;
    res = '0;
    for (int unsigned k = N_REQ; k >= 1; k--) begin
      idx = (32'(last) + k) % N_REQ;
      if (r[idx]) res = {1'b1, IDX_W'(idx)};
    end
    return res;
  endfunction

  sched_state_t      r_state;
  logic [IDX_W-1:0]  r_rr;
  logic [IDX_W-1:0]  r_gidx;
  logic [7:0]        r_tx_cnt;
  logic [7:0]        r_rx_cnt;
  logic              r_issued;
  logic              r_abort;
  logic [15:0]       r_gap;

  logic              w_busy;
  logic              w_xdone;
  logic              w_xslverr;
  logic [31:0]       w_xrdata;
  logic              w_start;
  logic              w_write;
  logic              w_xfer_state;
  logic [3:0]        w_off;
  logic [31:0]       w_wdata;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_tx_byte;
  logic [IDX_W:0]    w_pick;
  logic              w_unused;

  assign w_tx_byte = tx_data[{r_gidx, 3'b000} +: 8];
  assign w_pick    = rr_pick(req, r_rr);
  assign w_unused  = ^w_xrdata[31:8];

  always_comb begin
    w_write      = 1'b0;
    w_off        = OFF_TX_STATUS;
    w_wdata      = '0;
    w_xfer_state = 1'b1;
    case (r_state)
      ST_WR_NREADS: begin
        w_write = 1'b1;
        w_off   = OFF_N_READS;
        w_wdata = {24'b0, r_rx_cnt};
      end
      ST_TX_POLL: w_off = OFF_TX_STATUS;
      ST_TX_WR: begin
        w_write = 1'b1;
        w_off   = OFF_TX_DATA;
        w_wdata = {24'b0, w_tx_byte};
      end
      ST_RX_POLL: w_off = OFF_RX_STATUS;
      ST_RX_RD:   w_off = OFF_RX_DATA;
      default:    w_xfer_state = 1'b0;
    endcase
    w_addr  = BASE_ADDR + ADDR_W'(w_off);
    w_start = w_xfer_state && !r_issued && (r_gap == '0) && !w_busy;
  end

  apb_single_xfer #(.ADDR_W(ADDR_W)) u_xfer (
    .pclk    (pclk),
    .preset  (preset),
    .start   (w_start),
    .write   (w_write),
    .addr    (w_addr),
    .wdata   (w_wdata),
    .busy    (w_busy),
    .done    (w_xdone),
    .rdata   (w_xrdata),
    .slverr  (w_xslverr),
    .paddr   (paddr),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .pwdata  (pwdata),
    .pstrb   (pstrb),
    .pprot   (pprot),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state  <= ST_IDLE;
      r_rr     <= IDX_W'(N_REQ - 1);
      r_gidx   <= '0;
      r_tx_cnt <= '0;
      r_rx_cnt <= '0;
      r_issued <= 1'b0;
      r_abort  <= 1'b0;
      r_gap    <= '0;
      gnt      <= '0;
      tx_pop   <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      done     <= '0;
      err      <= 1'b0;
    end else begin
      tx_pop   <= 1'b0;
      rx_valid <= 1'b0;
      done     <= '0;
      err      <= 1'b0;
      if (w_start) r_issued <= 1'b1;
      if (w_xdone) r_issued <= 1'b0;
      if (r_gap != '0) r_gap <= r_gap - 16'd1;

      if (w_xdone && w_xslverr) begin
        r_state  <= ST_FINISH;
        r_abort  <= 1'b1;
        r_tx_cnt <= '0;
        r_rx_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: if (|req) r_state <= ST_ARB;
          ST_ARB: begin
            if (w_pick[IDX_W]) begin
              gnt      <= {{(N_REQ-1){1'b0}}, 1'b1} << w_pick[IDX_W-1:0];
              r_gidx   <= w_pick[IDX_W-1:0];
              r_rr     <= w_pick[IDX_W-1:0];
              r_tx_cnt <= n_tx[{w_pick[IDX_W-1:0], 3'b000} +: 8];
              r_rx_cnt <= n_rx[{w_pick[IDX_W-1:0], 3'b000} +: 8];
              if (n_tx[{w_pick[IDX_W-1:0], 3'b000} +: 8] == '0 &&
                  n_rx[{w_pick[IDX_W-1:0], 3'b000} +: 8] == '0)
                r_state <= ST_FINISH;
              else
                r_state <= ST_WR_NREADS;
            end else begin
              r_state <= ST_IDLE;
            end
          end
          ST_WR_NREADS: if (w_xdone)
            r_state <= (r_tx_cnt != '0) ? ST_TX_POLL : ST_RX_POLL;
          ST_TX_POLL: if (w_xdone) begin
            if (w_xrdata[FULL_BIT]) r_gap <= 16'(POLL_GAP);
            else                    r_state <= ST_TX_WR;
          end
          ST_TX_WR: if (w_xdone) begin
            tx_pop   <= 1'b1;
            r_tx_cnt <= r_tx_cnt - 8'd1;
            if (r_tx_cnt == 8'd1)
              r_state <= (r_rx_cnt != '0) ? ST_RX_POLL : ST_FINISH;
            else
              r_state <= ST_TX_POLL;
          end
          ST_RX_POLL: if (w_xdone) begin
            if (w_xrdata[EMPTY_BIT]) r_gap <= 16'(POLL_GAP);
            else                     r_state <= ST_RX_RD;
          end
          ST_RX_RD: if (w_xdone) begin
            rx_data  <= w_xrdata[7:0];
            rx_valid <= 1'b1;
            r_rx_cnt <= r_rx_cnt - 8'd1;
            r_state  <= (r_rx_cnt == 8'd1) ? ST_FINISH : ST_RX_POLL;
          end
          ST_FINISH: begin
            done    <= gnt;
            err     <= r_abort;
            r_abort <= 1'b0;
            gnt     <= '0;
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_xfer_scheduler.sv
// Directed bench with an APB slave model and scoreboard queues for APB
// transfers, RX bytes and grant order.
module tb_spi_xfer_scheduler;
  localparam int unsigned N_REQ    = 4;
  localparam int unsigned POLL_GAP = 4;

  logic               pclk = 1'b0;
  logic               preset = 1'b1;
  logic [N_REQ-1:0]   req = '0;
  logic [N_REQ*8-1:0] n_tx = '0, n_rx = '0, tx_data;
  logic [N_REQ-1:0]   gnt, done;
  logic               tx_pop, rx_valid, err;
  logic [7:0]         rx_data;
  logic [31:0]        paddr, pwdata;
  logic [31:0]        prdata = '0;
  logic               psel, penable, pwrite;
  logic               pready = 1'b1, pslverr = 1'b0;
  logic [3:0]         pstrb;
  logic [2:0]         pprot;

  always #5 pclk = ~pclk;

  spi_xfer_scheduler #(.N_REQ(N_REQ), .ADDR_W(32), .BASE_ADDR(32'h0), .POLL_GAP(POLL_GAP)) dut (
    .pclk(pclk), .preset(preset), .req(req), .n_tx(n_tx), .n_rx(n_rx), .tx_data(tx_data),
    .gnt(gnt), .tx_pop(tx_pop), .rx_data(rx_data), .rx_valid(rx_valid), .done(done), .err(err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pstrb(pstrb), .pprot(pprot), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  typedef struct { logic w; logic [31:0] a; logic [31:0] d; } apb_t;
  apb_t        exp_apb[$];
  logic [7:0]  exp_rx[$];
  int          exp_gnt[$];
  logic [31:0] tx_stat_q[$], rx_stat_q[$], rx_byte_q[$];
  logic [3:0]  txc [N_REQ];

  int checks = 0, failures = 0;
  int cyc = 0, xfer_cnt = 0, wr_cnt = 0, err_at = 0, last_poll = 0;
  int done_cnt = 0, gnt_cnt = 0, pop_cnt = 0, rxv_cnt = 0;
  logic [N_REQ-1:0] last_done = '0, prev_gnt = '0;
  logic last_err = 1'b0, multi_gnt = 1'b0, err_stray = 1'b0;
  logic stall_rd = 1'b0, gap_mon = 1'b0;

  always_comb
    for (int i = 0; i < N_REQ; i++) tx_data[i*8 +: 8] = {4'(i), txc[i]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push_apb(input logic w, input logic [31:0] a, input logic [31:0] d);
    apb_t e;
    e.w = w; e.a = a; e.d = d;
    exp_apb.push_back(e);
  endtask

  always @(negedge pclk) begin : mon
    apb_t e;
    int   g;
    cyc++;
    if (preset) begin
      for (int i = 0; i < N_REQ; i++) txc[i] = '0;
    end else if (tx_pop) begin
      pop_cnt++;
      for (int i = 0; i < N_REQ; i++) if (gnt[i]) txc[i] = txc[i] + 4'd1;
    end
    if (rx_valid) begin
      rxv_cnt++;
      if (exp_rx.size() != 0) chk("rx_data", {24'b0, rx_data}, {24'b0, exp_rx.pop_front()});
      else                    chk("rx_data", {24'b0, rx_data}, 32'h100);
    end
    if (done != '0) begin
      done_cnt++;
      last_done = done;
      last_err  = err;
    end else if (err) err_stray = 1'b1;
    if (!$onehot0(gnt)) multi_gnt = 1'b1;
    if (prev_gnt == '0 && gnt != '0) begin
      gnt_cnt++;
      g = (exp_gnt.size() != 0) ? exp_gnt.pop_front() : -1;
      chk("gnt_order", 32'(gnt), (g >= 0) ? (32'd1 << g) : 32'hFFFF_FFFF);
    end
    prev_gnt = gnt;

    pslverr = 1'b0;
    prdata  = '0;
    pready  = !(stall_rd && psel && !pwrite && paddr == 32'h8);
    if (psel && penable && pready) begin
      xfer_cnt++;
      if (exp_apb.size() != 0) e = exp_apb.pop_front();
      else begin e.w = 1'b0; e.a = 32'hFFFF_FFFF; e.d = '0; end
      chk("apb_write", 32'(pwrite), 32'(e.w));
      chk("apb_addr", paddr, e.a);
      chk("apb_strb", 32'(pstrb), e.w ? 32'hF : 32'h0);
      if (pwrite) begin
        chk("apb_wdata", pwdata, e.d);
        if (paddr == 32'h0) begin
          wr_cnt++;
          if (wr_cnt == err_at) pslverr = 1'b1;
        end
      end else begin
        case (paddr)
          32'h0: prdata = (tx_stat_q.size() != 0) ? tx_stat_q.pop_front() : 32'h2;
          32'h4: prdata = (rx_stat_q.size() != 0) ? rx_stat_q.pop_front() : 32'h0;
          32'h8: prdata = (rx_byte_q.size() != 0) ? rx_byte_q.pop_front() : 32'h0;
          default: prdata = '0;
        endcase
        if (gap_mon && paddr == 32'h0) begin
          if (last_poll != 0) chk("poll_gap", 32'(cyc - last_poll >= 6), 32'd1);
          last_poll = cyc;
        end
      end
    end
    if (!gap_mon) last_poll = 0;
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic wait_gnt(input int n);
    for (int i = 0; i < 3000 && gnt_cnt < n; i++) tick();
    chk("wait_grant", gnt_cnt, n);
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 3000 && done_cnt < n; i++) tick();
    chk("wait_done", done_cnt, n);
  endtask

  task automatic reset_and_check();
    preset = 1'b1;
    repeat (3) tick();
    chk("rst_psel", 32'(psel), 0);
    chk("rst_penable", 32'(penable), 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_tx_pop", 32'(tx_pop), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_pstrb", 32'(pstrb), 0);
    chk("rst_pprot", 32'(pprot), 0);
    chk("rst_paddr", paddr, 0);
    preset = 1'b0;
    tick();
  endtask

  initial begin : stim
    int snap;
    logic found;
    reset_and_check();

    // Requester 0: three TX bytes, no RX
    n_tx[7:0] = 8'd3;
    push_apb(1, 32'hC, 0);
    for (int b = 0; b < 3; b++) begin push_apb(0, 32'h0, 0); push_apb(1, 32'h0, 32'(b)); end
    exp_gnt.push_back(0);
    req = 4'b0001; wait_gnt(1); req = '0;
    wait_done(1);
    chk("a_done", 32'(last_done), 32'h1);
    chk("a_err", 32'(last_err), 0);
    chk("a_pops", pop_cnt, 3);
    chk("a_rx_none", rxv_cnt, 0);
    chk("a_apb_left", exp_apb.size(), 0);

    // Requester 1: one TX byte, two RX bytes with one empty poll
    n_tx[15:8] = 8'd1; n_rx[15:8] = 8'd2;
    rx_stat_q.push_back(32'h2);
    rx_byte_q.push_back(32'hA5); rx_byte_q.push_back(32'h3C);
    exp_rx.push_back(8'hA5); exp_rx.push_back(8'h3C);
    push_apb(1, 32'hC, 2); push_apb(0, 32'h0, 0); push_apb(1, 32'h0, 32'h10);
    push_apb(0, 32'h4, 0); push_apb(0, 32'h4, 0); push_apb(0, 32'h8, 0);
    push_apb(0, 32'h4, 0); push_apb(0, 32'h8, 0);
    exp_gnt.push_back(1);
    req = 4'b0010; wait_gnt(2); req = '0;
    wait_done(2);
    chk("b_done", 32'(last_done), 32'h2);
    chk("b_rx_cnt", rxv_cnt, 2);
    chk("b_apb_left", exp_apb.size(), 0);

    // Requester 2: TX FIFO full twice, polls spaced by POLL_GAP
    n_tx[23:16] = 8'd1;
    tx_stat_q.push_back(32'h8); tx_stat_q.push_back(32'h8); tx_stat_q.push_back(32'h2);
    gap_mon = 1'b1;
    push_apb(1, 32'hC, 0);
    repeat (3) push_apb(0, 32'h0, 0);
    push_apb(1, 32'h0, 32'h20);
    exp_gnt.push_back(2);
    req = 4'b0100; wait_gnt(3); req = '0;
    wait_done(3);
    gap_mon = 1'b0;
    chk("c_done", 32'(last_done), 32'h4);
    chk("c_stat_left", tx_stat_q.size(), 0);
    chk("c_apb_left", exp_apb.size(), 0);

    // All four requesting after reset: rotation 0,1,2,3,0
    reset_and_check();
    n_tx = {4{8'd1}}; n_rx = '0;
    for (int k = 0; k < 5; k++) begin
      exp_gnt.push_back(k % 4);
      push_apb(1, 32'hC, 0); push_apb(0, 32'h0, 0);
      push_apb(1, 32'h0, (k < 4) ? 32'(k * 16) : 32'h01);
    end
    req = 4'b1111; wait_gnt(8); req = '0;
    wait_done(8);
    chk("d_done_last", 32'(last_done), 32'h1);
    chk("d_gnt_left", exp_gnt.size(), 0);
    chk("d_apb_left", exp_apb.size(), 0);

    // Requester 1, four TX bytes, slave error on the second data write
    n_tx[15:8] = 8'd4;
    err_at = wr_cnt + 2;
    push_apb(1, 32'hC, 0); push_apb(0, 32'h0, 0); push_apb(1, 32'h0, 32'h11);
    push_apb(0, 32'h0, 0); push_apb(1, 32'h0, 32'h12);
    exp_gnt.push_back(1);
    req = 4'b0010; wait_gnt(9); req = '0;
    wait_done(9);
    chk("e_done", 32'(last_done), 32'h2);
    chk("e_err", 32'(last_err), 1);
    snap = xfer_cnt;
    repeat (12) tick();
    chk("e_no_more_apb", xfer_cnt, snap);
    chk("e_gnt_idle", 32'(gnt), 0);
    chk("e_apb_left", exp_apb.size(), 0);
    err_at = 0;

    // Requester 2 RX read stalled in ACCESS, then reset
    n_tx[23:16] = 8'd0; n_rx[23:16] = 8'd1;
    push_apb(1, 32'hC, 1); push_apb(0, 32'h4, 0);
    exp_gnt.push_back(2);
    stall_rd = 1'b1;
    req = 4'b0100;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      tick();
      found = psel && penable && (paddr == 32'h8);
    end
    chk("f_rd_access", 32'(found), 1);
    preset = 1'b1; req = '0;
    @(posedge pclk);
    @(negedge pclk);
    chk("f_psel", 32'(psel), 0);
    chk("f_penable", 32'(penable), 0);
    chk("f_gnt", 32'(gnt), 0);
    chk("f_rx_valid", 32'(rx_valid), 0);
    chk("f_apb_left", exp_apb.size(), 0);
    tick();
    preset = 1'b0; stall_rd = 1'b0;
    tick();
    n_tx[7:0] = 8'd1; n_rx[7:0] = 8'd0;
    push_apb(1, 32'hC, 0); push_apb(0, 32'h0, 0); push_apb(1, 32'h0, 32'h00);
    exp_gnt.push_back(0);
    req = 4'b0101; wait_gnt(11); req = '0;
    wait_done(10);
    chk("f_done", 32'(last_done), 32'h1);
    chk("f_apb_left2", exp_apb.size(), 0);

    chk("multi_gnt", 32'(multi_gnt), 0);
    chk("err_stray", 32'(err_stray), 0);
    chk("rx_left", exp_rx.size(), 0);
    chk("gnt_left", exp_gnt.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_xfer_scheduler.md
Name: spi_xfer_scheduler

Overview:
APB master sequencer that shares one apb_2_spi peripheral between N_REQ requesters using round-robin arbitration.
Each requester asks for one SPI transaction (n_tx bytes written, n_rx bytes read back). The block programs N_READS, pushes TX bytes with TX-FIFO flow control, polls the RX FIFO and returns RX bytes to the granted requester.
It sits between client logic and the apb_2_spi APB slave port.

Parameters:
N_REQ, 4, number of requesters (2..8)
ADDR_W, 32, APB address width
BASE_ADDR, 0, base address of apb_2_spi; register offsets are added to it
POLL_GAP, 4, idle cycles between consecutive status polls (0 allowed)

Ports:
pclk  in  1  clock
preset  in  1  reset; synchronous, active-high
req  in  N_REQ  per-requester transaction request, level
n_tx  in  N_REQ*8  per-requester TX byte count, slice i = [8i+7:8i]
n_rx  in  N_REQ*8  per-requester RX byte count
tx_data  in  N_REQ*8  per-requester next TX byte
gnt  out  N_REQ  one-hot grant, held for the whole transaction
tx_pop  out  1  1-cycle pulse: granted requester's tx_data was consumed; present the next byte on the following cycle
rx_data  out  8  RX byte for the granted requester
rx_valid  out  1  1-cycle qualifier for rx_data
done  out  N_REQ  1-cycle pulse on the granted index at transaction end
err  out  1  1-cycle pulse coincident with done when aborted on pslverr
paddr  out  ADDR_W  APB address
psel, penable, pwrite  out  1  APB control
pwdata  out  32  APB write data
pstrb  out  4  APB strobes; always 4'b1111 on writes, 0 on reads
pprot  out  3  always 3'b000
prdata  in  32  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error

Behaviour:
- Register offsets: TX_DATA/TX_STATUS 0x0 (write/read), RX_STATUS 0x4, RX_DATA 0x8, N_READS 0xC.
- Status bits: FULL bit3, ALMOST_FULL bit2, EMPTY bit1, ALMOST_EMPTY bit0.
- Reset (synchronous): all outputs 0, state IDLE, rr pointer = N_REQ-1, counters 0. Any in-flight APB transfer is abandoned with psel dropped at the reset edge.
- APB transfer engine:
  - SETUP phase: psel=1, penable=0, for 1 cycle.
  - ACCESS phase: psel=1, penable=1, held until pready=1.
  - prdata and pslverr are sampled on that edge. psel and penable return to 0 for at least 1 cycle; no back-to-back transfers.
  - Each transfer therefore takes at least 3 cycles.
- FSM states: IDLE, ARB, WR_NREADS, TX_POLL, TX_WR, RX_POLL, RX_RD, FINISH.
- IDLE: any req bit set -> ARB.
- ARB (1 cycle):
  - Grant the first set req index searching from rr+1 modulo N_REQ; gnt is asserted.
  - n_tx and n_rx of the winner are latched and rr is updated.
  - If n_tx=0 and n_rx=0 -> FINISH with no APB access. Otherwise -> WR_NREADS.
- WR_NREADS: write n_rx (zero-extended) to N_READS. Then go to TX_POLL if n_tx>0, else RX_POLL.
- TX_POLL: read TX_STATUS.
  - FULL=1: wait POLL_GAP cycles, then re-poll.
  - FULL=0: -> TX_WR.
- TX_WR:
  - Write {24'b0, tx_data[granted]} to TX_DATA; tx_pop pulses on the completing edge.
  - Decrement the TX count. If the count is nonzero -> TX_POLL.
  - If it is zero -> RX_POLL when n_rx>0, else FINISH.
- RX_POLL: read RX_STATUS.
  - EMPTY=1: wait POLL_GAP cycles, then re-poll.
  - Otherwise -> RX_RD.
- RX_RD:
  - Read RX_DATA; rx_data = prdata[7:0] and rx_valid pulses on the following cycle.
  - Decrement the RX count; -> RX_POLL if the count is nonzero, else FINISH.
- FINISH (1 cycle): done[granted]=1, then gnt=0 -> IDLE. A requester still holding req competes again from ARB.
- pslverr=1 on any transfer: abort immediately -> FINISH with err=1; remaining counts are discarded.
- req dropped mid-transaction: ignored; the transaction completes. req, n_tx and n_rx of other requesters are not sampled outside ARB.
- There is no timeout on polling; a stuck peripheral stalls the block until reset.

Decomposition:
- Package spi_sched_pkg holds:
  - register offset localparams;
  - status bit-index localparams (FULL_BIT=3, EMPTY_BIT=1, ...);
  - typedef enum logic [2:0] sched_state_t for the FSM states.
- One sub-module, apb_single_xfer: start, write, addr, wdata in; busy, done, rdata, slverr out. It drives the APB pins.
- The round-robin pick is a function inside the top module.

Test Plan:
- Single requester 0, n_tx=3, n_rx=0, slave ready after 1 cycle -> APB sequence: write 0 to 0xC, then three read-0x0/write-0x0 pairs with data 0,1,2. tx_pop pulses 3 times; done[0] pulses once; no RX access.
- Requester 1, n_tx=1, n_rx=2; SPI slave model returns 0xA5, 0x3C -> rx_valid pulses twice with rx_data 0xA5 then 0x3C; done[1]=1.
- TX_STATUS returns FULL (0x8) twice then EMPTY (0x2), POLL_GAP=4 -> three status reads, each ≥4 idle cycles apart; one data write.
- req=4'b1111 held, each with n_tx=1 -> grants in order 0,1,2,3,0; never two gnt bits high.
- pslverr=1 on the second TX write of n_tx=4 -> err and done pulse together; no further APB accesses; gnt=0.
- preset asserted during the ACCESS phase of an RX_RD -> psel, penable, gnt and rx_valid are 0 at the next edge. Afterwards a new req is served from requester 0.
